// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared types and constants for the data-memory responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_BUSY = 2'd1,
        DM_RESP = 2'd2
    } dm_state_t;

    localparam logic [1:0] DM_LANE0 = 2'd0;
    localparam logic [1:0] DM_LANE1 = 2'd1;
    localparam logic [1:0] DM_LANE2 = 2'd2;
    localparam logic [1:0] DM_LANE3 = 2'd3;

    // Error codes as seen by the core's memory stage; any non-OK code raises resp_err.
    typedef enum logic [1:0] {
        DM_ERR_NONE     = 2'd0,
        DM_ERR_MISALIGN = 2'd1,
        DM_ERR_RANGE    = 2'd2
    } dm_err_t;

    // Range errors take priority over alignment errors.
    function automatic dm_err_t dm_classify(input logic out_of_range,
                                            input logic is_byte,
                                            input logic [1:0] lane);
        if (out_of_range)
            return DM_ERR_RANGE;
        else if (!is_byte && (lane != DM_LANE0))
            return DM_ERR_MISALIGN;
        else
            return DM_ERR_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_mux.sv
// ============================================================================
//  Module   : dmem_lane_mux
//  Brief    : Little-endian byte extract and byte merge for one 32-bit word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_mux
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  new_byte,
    output logic [7:0]  byte_out,
    output logic [31:0] merged
);

    always_comb begin
        byte_out = 8'd0;
        merged   = word;
        case (lane)
            DM_LANE0: begin
                byte_out      = word[7:0];
                merged[7:0]   = new_byte;
            end
            DM_LANE1: begin
                byte_out      = word[15:8];
                merged[15:8]  = new_byte;
            end
            DM_LANE2: begin
                byte_out      = word[23:16];
                merged[23:16] = new_byte;
            end
            default: begin
                byte_out      = word[31:24];
                merged[31:24] = new_byte;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Wait-state data-memory responder with valid/ready request and response.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
        end
    endgenerate

    dm_state_t          state;
    dm_state_t          state_next;
    logic [3:0]         wait_cnt;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic               lat_write;
    logic               lat_byte;
    logic [31:0]        mem [DEPTH];

    logic [ADDR_W-3:0]  word_idx;
    logic [1:0]         lane;
    logic [31:0]        old_word;
    logic [7:0]         lane_byte;
    logic [31:0]        merged_word;
    dm_err_t            err_code;
    logic               commit;
    logic               mem_we;

    assign word_idx  = lat_addr[ADDR_W-1:2];
    assign lane      = lat_addr[1:0];
    assign old_word  = mem[word_idx];
    assign err_code  = dm_classify((lat_addr >> ADDR_W) != 32'd0, lat_byte, lane);
    assign commit    = (state == DM_BUSY) && (wait_cnt == 4'd0);
    // Reset in the commit cycle must suppress the store.
    assign mem_we    = commit && lat_write && (err_code == DM_ERR_NONE) && !rst;
    assign req_ready = (state == DM_IDLE);

    dmem_lane_mux u_lane_mux (
        .word     (old_word),
        .lane     (lane),
        .new_byte (lat_wdata[7:0]),
        .byte_out (lane_byte),
        .merged   (merged_word)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= DM_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DM_IDLE: if (req_valid)               state_next = DM_BUSY;
            DM_BUSY: if (wait_cnt == 4'd0)        state_next = DM_RESP;
            DM_RESP: if (resp_valid && resp_ready) state_next = DM_IDLE;
            default:                              state_next = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_write  <= 1'b0;
            lat_byte   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                DM_IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_write <= req_write;
                        lat_byte  <= req_byte;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                    end
                end
                DM_BUSY: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        resp_err <= (err_code != DM_ERR_NONE);
                        if (lat_write || (err_code != DM_ERR_NONE))
                            resp_rdata <= 32'd0;
                        else if (lat_byte)
                            resp_rdata <= {24'd0, lane_byte};
                        else
                            resp_rdata <= old_word;
                    end
                end
                DM_RESP: begin
                    // resp_valid rises one cycle after the commit cycle.
                    resp_valid <= !(resp_valid && resp_ready);
                end
                default: resp_valid <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[word_idx] <= lat_byte ? merged_word : lat_wdata;
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed scoreboard bench for data_mem_responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int W = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Waits for req_ready, issues one request, pushes its expectation, then
    // waits for and checks the response. hold>0 stalls resp_ready in RESP
    // while pulsing a bogus store that must not be accepted.
    task automatic do_req(input string tag, input logic [31:0] addr, input logic wr,
                          input logic bt, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er, input int hold);
        int   lat;
        exp_t e;
        for (int i = 0; i < 40 && !req_ready; i++) @(posedge clk) #1;
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_byte = bt; req_wdata = wd;
        @(posedge clk);
        sb.push_back('{rdata: exp_rd, err: exp_er});
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_write = ~wr; req_wdata = ~wd;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid) break;
        end
        check({tag, "_latency"}, lat, W + 2);
        e = sb.pop_front();
        check({tag, "_rdata"}, resp_rdata, e.rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_addr = 32'h0000_0010; req_write = 1'b1;
            req_byte = 1'b0; req_wdata = 32'h0BAD_0BAD;
            @(posedge clk) #1;
            check($sformatf("%s_hold%0d_valid", tag, h), {31'd0, resp_valid}, 32'd1);
            check($sformatf("%s_hold%0d_rdata", tag, h), resp_rdata, e.rdata);
            check($sformatf("%s_hold%0d_ready", tag, h), {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk) #1;
        resp_ready = 1'b0;
        check({tag, "_retire_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_retire_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0;
        req_byte = 1'b0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);

        do_req("st_w_010",  32'h010, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0,          1'b0, 0);
        do_req("ld_w_010",  32'h010, 1'b0, 1'b0, 32'd0,         32'hDEAD_BEEF,  1'b0, 0);
        do_req("ld_b_013",  32'h013, 1'b0, 1'b1, 32'd0,         32'h0000_00DE,  1'b0, 0);
        do_req("st_b_011",  32'h011, 1'b1, 1'b1, 32'hAAAA_AA55, 32'd0,          1'b0, 0);
        do_req("ld_w_010b", 32'h010, 1'b0, 1'b0, 32'd0,         32'hDEAD_55EF,  1'b0, 0);
        do_req("ld_b_010",  32'h010, 1'b0, 1'b1, 32'd0,         32'h0000_00EF,  1'b0, 0);
        do_req("ld_w_012",  32'h012, 1'b0, 1'b0, 32'd0,         32'd0,          1'b1, 0);
        do_req("st_w_012",  32'h012, 1'b1, 1'b0, 32'h0123_4567, 32'd0,          1'b1, 0);
        do_req("st_w_000",  32'h000, 1'b1, 1'b0, 32'h1122_3344, 32'd0,          1'b0, 0);
        do_req("st_oor",    32'h1000, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0,         1'b1, 0);
        do_req("ld_oor",    32'h1000, 1'b0, 1'b0, 32'd0,        32'd0,          1'b1, 0);
        do_req("ld_w_000",  32'h000, 1'b0, 1'b0, 32'd0,         32'h1122_3344,  1'b0, 0);

        // Stalled response with a bogus store pulsed at 0x010 during the hold.
        do_req("ld_hold",   32'h010, 1'b0, 1'b0, 32'd0,         32'hDEAD_55EF,  1'b0, 5);
        do_req("ld_after",  32'h010, 1'b0, 1'b0, 32'd0,         32'hDEAD_55EF,  1'b0, 0);

        // Store interrupted by reset while still waiting must not land.
        do_req("st_w_020",  32'h020, 1'b1, 1'b0, 32'hCAFE_F00D, 32'd0,          1'b0, 0);
        req_valid = 1'b1; req_addr = 32'h020; req_write = 1'b1;
        req_byte = 1'b0; req_wdata = 32'h1234_5678;
        @(posedge clk) #1;
        req_valid = 1'b0;
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
        do_req("ld_w_020",  32'h020, 1'b0, 1'b0, 32'd0,         32'hCAFE_F00D,  1'b0, 0);

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
